// File: rtl/lcd1602_ctrl.sv
// HD44780 (LCD1602) 8-bit write scheduler: power-up wait, fixed init sequence, then a 4-deep request FIFO.
// Optional cursor tracking with automatic line wrap is enabled by defining LCD1602_CURSOR_TRACK_EN.
module lcd1602_ctrl #(
    parameter int PWRUP_CYC = 750000,
    parameter int SETUP_CYC = 4,
    parameter int E_CYC     = 256,
    parameter int HOLD_CYC  = 4,
    parameter int EXEC_CYC  = 2500,
    parameter int CLR_CYC   = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic       wr_rs,
    input  logic [7:0] wr_data,
    output logic       init_done,
    output logic       busy,
    output logic [7:0] lcd_dat,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en
);

    localparam logic [31:0] L_PWRUP = 32'(PWRUP_CYC - 1);
    localparam logic [31:0] L_SETUP = 32'(SETUP_CYC - 1);
    localparam logic [31:0] L_E     = 32'(E_CYC - 1);
    localparam logic [31:0] L_HOLD  = 32'(HOLD_CYC - 1);
    localparam logic [31:0] L_EXEC  = 32'(EXEC_CYC - 1);
    localparam logic [31:0] L_CLR   = 32'(CLR_CYC - 1);

    typedef enum logic [2:0] {
        S_PWRUP, S_INIT_LD, S_IDLE, S_SETUP, S_EN_HI, S_HOLD, S_WAIT
    } state_t;

    state_t      r_state;
    logic [31:0] r_cnt;
    logic [1:0]  r_step;
    logic        r_init_done;
    logic [7:0]  r_lcd_dat;
    logic        r_lcd_rs;
    logic        r_lcd_en;

    logic [8:0]  r_fifo [4];
    logic [1:0]  r_wptr;
    logic [1:0]  r_rptr;
    logic [2:0]  r_count;

    logic        w_push;
    logic        w_pop;
    logic        w_ins_pend;
    logic        w_long;
    logic [31:0] w_wait_last;
    logic [7:0]  w_init_cmd;

`ifdef LCD1602_CURSOR_TRACK_EN
    logic [4:0]  r_col;
    logic        r_ins_pend;
    logic [7:0]  r_ins_dat;
    assign w_ins_pend = r_ins_pend;
`else
    assign w_ins_pend = 1'b0;
`endif

    assign wr_ready    = (r_count != 3'd4);
    assign w_push      = wr_valid && wr_ready;
    // A pending line-wrap instruction takes the load slot ahead of the FIFO head.
    assign w_pop       = (r_state == S_IDLE) && r_init_done && (r_count != 3'd0) && !w_ins_pend;
    assign busy        = !((r_state == S_IDLE) && (r_count == 3'd0));
    assign w_long      = !r_lcd_rs && (r_lcd_dat[7:2] == 6'd0) && (r_lcd_dat[1:0] != 2'd0);
    assign w_wait_last = w_long ? L_CLR : L_EXEC;

    assign init_done = r_init_done;
    assign lcd_dat   = r_lcd_dat;
    assign lcd_rs    = r_lcd_rs;
    assign lcd_en    = r_lcd_en;
    assign lcd_rw    = 1'b0;

    always_comb begin
        w_init_cmd = 8'h38;
        case (r_step)
            2'd0: w_init_cmd = 8'h38;
            2'd1: w_init_cmd = 8'h0C;
            2'd2: w_init_cmd = 8'h06;
            2'd3: w_init_cmd = 8'h01;
            default: w_init_cmd = 8'h38;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wptr] <= {wr_rs, wr_data};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_PWRUP;
            r_cnt       <= '0;
            r_step      <= '0;
            r_init_done <= 1'b0;
            r_lcd_dat   <= '0;
            r_lcd_rs    <= 1'b0;
            r_lcd_en    <= 1'b0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
`ifdef LCD1602_CURSOR_TRACK_EN
            r_col       <= '0;
            r_ins_pend  <= 1'b0;
            r_ins_dat   <= '0;
`endif
        end else begin
            if (w_push) r_wptr <= r_wptr + 2'd1;
            if (w_pop)  r_rptr <= r_rptr + 2'd1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: ;
            endcase

            case (r_state)
                S_PWRUP: begin
                    if (r_cnt == L_PWRUP) begin
                        r_cnt   <= '0;
                        r_state <= S_INIT_LD;
                    end else r_cnt <= r_cnt + 32'd1;
                end
                S_INIT_LD: begin
                    r_lcd_rs  <= 1'b0;
                    r_lcd_dat <= w_init_cmd;
                    r_state   <= S_SETUP;
                end
                S_IDLE: begin
                    if (r_init_done && (r_count != 3'd0)) begin
`ifdef LCD1602_CURSOR_TRACK_EN
                        if (r_ins_pend) begin
                            r_lcd_rs   <= 1'b0;
                            r_lcd_dat  <= r_ins_dat;
                            r_ins_pend <= 1'b0;
                        end else begin
                            {r_lcd_rs, r_lcd_dat} <= r_fifo[r_rptr];
                        end
`else
                        {r_lcd_rs, r_lcd_dat} <= r_fifo[r_rptr];
`endif
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (r_cnt == L_SETUP) begin
                        r_cnt    <= '0;
                        r_lcd_en <= 1'b1;
                        r_state  <= S_EN_HI;
                    end else r_cnt <= r_cnt + 32'd1;
                end
                S_EN_HI: begin
                    if (r_cnt == L_E) begin
                        r_cnt    <= '0;
                        r_lcd_en <= 1'b0;
                        r_state  <= S_HOLD;
                    end else r_cnt <= r_cnt + 32'd1;
                end
                S_HOLD: begin
                    if (r_cnt == L_HOLD) begin
                        r_cnt   <= '0;
                        r_state <= S_WAIT;
                    end else r_cnt <= r_cnt + 32'd1;
                end
                S_WAIT: begin
                    if (r_cnt == w_wait_last) begin
                        r_cnt <= '0;
`ifdef LCD1602_CURSOR_TRACK_EN
                        // Column 15->16 wraps to line 2, 31->32 wraps back to line 1.
                        if (r_lcd_rs) begin
                            if (r_col == 5'd15) begin
                                r_col      <= 5'd16;
                                r_ins_pend <= 1'b1;
                                r_ins_dat  <= 8'hC0;
                            end else if (r_col == 5'd31) begin
                                r_col      <= 5'd0;
                                r_ins_pend <= 1'b1;
                                r_ins_dat  <= 8'h80;
                            end else r_col <= r_col + 5'd1;
                        end else if (w_long) begin
                            r_col <= 5'd0;
                        end else if (r_lcd_dat[7]) begin
                            r_col <= {r_lcd_dat[6], r_lcd_dat[3:0]};
                        end
`endif
                        if (r_init_done) begin
                            r_state <= S_IDLE;
                        end else if (r_step == 2'd3) begin
                            r_init_done <= 1'b1;
                            r_state     <= S_IDLE;
                        end else begin
                            r_step  <= r_step + 2'd1;
                            r_state <= S_INIT_LD;
                        end
                    end else r_cnt <= r_cnt + 32'd1;
                end
                default: r_state <= S_PWRUP;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd1602_ctrl.sv
// Scoreboard bench for lcd1602_ctrl: expected bus writes are queued at issue, a monitor checks them at each E rise.
// Cursor-wrap scenario is exercised only when LCD1602_CURSOR_TRACK_EN is defined.
module tb_lcd1602_ctrl;
    localparam int PW = 20, SU = 2, EW = 4, HO = 2, EX = 10, CL = 40;
    localparam int INIT_DONE_CYC = PW + 3 * (EX + SU + EW + HO + 1) + (CL + SU + EW + HO + 1);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_valid = 1'b0;
    logic       wr_rs = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ready, init_done, busy, lcd_rs, lcd_rw, lcd_en;
    logic [7:0] lcd_dat;

    lcd1602_ctrl #(
        .PWRUP_CYC(PW), .SETUP_CYC(SU), .E_CYC(EW), .HOLD_CYC(HO), .EXEC_CYC(EX), .CLR_CYC(CL)
    ) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_rs(wr_rs),
        .wr_data(wr_data), .init_done(init_done), .busy(busy), .lcd_dat(lcd_dat),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         failures = 0;
    int         cyc;
    int         acc_cyc;
    logic [8:0] exp_q [$];
    int         rise_q [$];
    logic       prev_en = 1'b0;
    int         width = 0;
    bit         rw_bad = 1'b0;
    logic [8:0] mon_e;
    logic [8:0] bp [6] = '{9'h130, 9'h131, 9'h080, 9'h132, 9'h178, 9'h179};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, expv);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Monitor: every E rise must match the head of the expected queue.
    always @(negedge clk) begin
        if (lcd_rw !== 1'b0) rw_bad = 1'b1;
        if (rst) begin
            prev_en = 1'b0;
            width   = 0;
        end else begin
            if (lcd_en && !prev_en) begin
                rise_q.push_back(cyc);
                width = 1;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write actual=%0h_%02h expected=none", lcd_rs, lcd_dat);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("write_data", {23'd0, lcd_rs, lcd_dat}, {23'd0, mon_e});
                end
            end else if (lcd_en) begin
                width++;
            end else if (prev_en) begin
                check("e_width", width, EW);
            end
            prev_en = lcd_en;
        end
    end

    task automatic push(input logic rs, input logic [7:0] d);
        int n;
        n = 0;
        @(negedge clk);
        wr_valid = 1'b1; wr_rs = rs; wr_data = d;
        #1;
        while (!wr_ready && n < 2000) begin
            @(negedge clk); #1; n++;
        end
        if (!wr_ready) begin
            check("push_timeout", 0, 1);
            wr_valid = 1'b0;
        end else begin
            exp_q.push_back({rs, d});
            @(posedge clk); #1;
            wr_valid = 1'b0;
            acc_cyc  = cyc;
        end
    endtask

    task automatic wait_idle(output int t);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 3000) begin
            @(negedge clk); n++;
        end
        if (busy) check("idle_timeout", 0, 1);
        t = cyc;
    endtask

    task automatic wait_init();
        int n;
        n = 0;
        @(negedge clk);
        while (!init_done && n < 1000) begin
            @(negedge clk); n++;
        end
        check("init_done_cycle", init_done ? cyc : -1, INIT_DONE_CYC);
    endtask

    task automatic push_init_exp();
        exp_q.push_back(9'h038);
        exp_q.push_back(9'h00C);
        exp_q.push_back(9'h006);
        exp_q.push_back(9'h001);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int t, idx, rexp, n;
        repeat (3) @(negedge clk);
        check("rst_en", lcd_en, 0);
        check("rst_dat", lcd_dat, 0);
        check("rst_rs", lcd_rs, 0);
        check("rst_init_done", init_done, 0);
        check("rst_busy", busy, 1);
        check("rst_ready", wr_ready, 1);

        push_init_exp();
        rst = 1'b0;
        // Six back-to-back requests during power-up: only four fit.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            wr_valid = 1'b1; wr_rs = bp[i][8]; wr_data = bp[i][7:0];
            #1;
            check("bp_ready", wr_ready, (i < 4) ? 1 : 0);
            if (i < 4) exp_q.push_back(bp[i]);
        end
        @(negedge clk);
        wr_valid = 1'b0;
        check("pwrup_en_low", lcd_en, 0);

        wait_init();
        check("init_rises", rise_q.size(), 4);
        if (rise_q.size() >= 4) begin
            check("first_e_rise", rise_q[0], PW + 1 + SU);
            check("init_spacing", rise_q[3] - rise_q[0], 3 * (EX + SU + EW + HO + 1));
        end

        wait_idle(t);
        check("bp_drained", exp_q.size(), 0);
        push(bp[4][8], bp[4][7:0]);
        push(bp[5][8], bp[5][7:0]);
        wait_idle(t);

        // Single data write latency and busy release.
        push(1'b1, 8'h48);
        rexp = acc_cyc + 1 + SU;
        wait_idle(t);
        check("h_rise", rise_q[rise_q.size() - 1], rexp);
        check("busy_fall", t, rexp + EW + HO + EX);

        // Clear then data: long wait, then normal.
        idx = rise_q.size();
        push(1'b0, 8'h01);
        push(1'b1, 8'h41);
        push(1'b1, 8'h42);
        wait_idle(t);
        check("clr_rises", rise_q.size(), idx + 3);
        if (rise_q.size() >= idx + 3) begin
            check("clr_gap", rise_q[idx + 1] - rise_q[idx], 49);
            check("norm_gap", rise_q[idx + 2] - rise_q[idx + 1], 19);
        end

        // Reset while E is high.
        push(1'b1, 8'h5A);
        push(1'b1, 8'h57);
        n = 0;
        @(negedge clk);
        while (!lcd_en && n < 100) begin
            @(negedge clk); n++;
        end
        check("midpulse_en_seen", lcd_en, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_en_async", lcd_en, 0);
        check("rst_init_clr", init_done, 0);
        check("rst_dat_clr", lcd_dat, 0);
        exp_q.delete();
        rise_q.delete();
        push_init_exp();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_init();
        check("fifo_flushed", busy, 0);
        repeat (30) @(negedge clk);
        check("reinit_rises", rise_q.size(), 4);
        check("reinit_exp_empty", exp_q.size(), 0);

`ifdef LCD1602_CURSOR_TRACK_EN
        for (int i = 0; i < 17; i++) begin
            if (i == 16) exp_q.push_back(9'h0C0);
            push(1'b1, 8'h61 + 8'(i));
        end
        wait_idle(t);
        check("wrap_exp_empty", exp_q.size(), 0);
`endif

        check("lcd_rw_zero", rw_bad, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
